// File: rtl/ptw_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ptw_mem_arbiter
//
// Shares one page-table memory read port among NUM_REQ page-table walkers.
// Round-robin grant, one read outstanding at a time, registered response back
// to the granted walker, and a watchdog that turns a stalled memory read into
// an error response.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   req_read       per-walker read request (level, held until serviced)
//   req_addr       per-walker PTE address, slice i = [i*AW +: AW]
//   rsp_ready      one-cycle pulse to the walker whose read completed
//   rsp_data       PTE data, valid while a rsp_ready bit is high, else 0
//   rsp_error      qualifies rsp_ready: 1 = watchdog timeout, rsp_data = 0
//   mem_addr       shared memory port address (stable through BUSY)
//   mem_read       shared memory port read strobe (level)
//   mem_data       memory read data, valid with mem_ready
//   mem_ready      memory completion pulse
//   busy           high in BUSY or RESP
//   grant_id       index of the current / last granted walker
//   stat_grants    per-walker 16-bit saturating grant counters
//   stat_timeouts  16-bit saturating timeout counter
//
// Build option
//   PTW_ARB_STATS_EN  when defined, the statistics counters are built;
//                     otherwise stat_grants / stat_timeouts are tied to 0.
//
// State table
//   IDLE | waiting for a request; arbitrates round-robin from rr_ptr
//   BUSY | read issued on the memory port, watchdog running
//   RESP | one-cycle response to the granted walker, rr_ptr advances
// ----------------------------------------------------------------------------
module ptw_mem_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int AW             = 48,
   parameter int DW             = 48,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_read,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   output logic [NUM_REQ-1:0]    rsp_ready,
   output logic [DW-1:0]         rsp_data,
   output logic                  rsp_error,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_read,
   input  logic [DW-1:0]         mem_data,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic [1:0]            grant_id,
   output logic [NUM_REQ*16-1:0] stat_grants,
   output logic [15:0]           stat_timeouts
);

   localparam bit              WDOG_EN   = (TIMEOUT_CYCLES > 0);
   localparam int              WDW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDW-1:0]  WDOG_LAST = WDW'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [1:0]      LAST_ID   = 2'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [1:0]           grant_id_q, grant_id_d;
   logic [AW-1:0]        mem_addr_q, mem_addr_d;
   logic                 mem_read_q, mem_read_d;
   logic [WDW-1:0]       wdog_q, wdog_d;
   logic [NUM_REQ-1:0]   rsp_ready_q, rsp_ready_d;
   logic [DW-1:0]        rsp_data_q, rsp_data_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 busy_q, busy_d;

   logic                 grant_evt;
   logic                 tmo_evt;

   // Round-robin pick: first requesting walker at or after rr_ptr.
   logic                 arb_hit;
   logic [1:0]           arb_id;
   logic [AW-1:0]        arb_addr;

   always_comb begin
      int idx;
      idx     = 0;
      arb_hit = 1'b0;
      arb_id  = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!arb_hit && req_read[idx]) begin
            arb_hit = 1'b1;
            arb_id  = 2'(idx);
         end
      end
      arb_addr = req_addr[int'(arb_id)*AW +: AW];
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      wdog_d      = wdog_q;
      rsp_ready_d = '0;
      rsp_data_d  = '0;
      rsp_error_d = 1'b0;
      grant_evt   = 1'b0;
      tmo_evt     = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_hit) begin
               state_d    = BUSY;
               grant_id_d = arb_id;
               mem_addr_d = arb_addr;
               mem_read_d = 1'b1;
               wdog_d     = '0;
               grant_evt  = 1'b1;
            end
         end
         BUSY: begin
            // A completion on the expiry cycle takes priority over the timeout.
            if (mem_ready) begin
               state_d     = RESP;
               mem_read_d  = 1'b0;
               rsp_ready_d = NUM_REQ'(1) << grant_id_q;
               rsp_data_d  = mem_data;
            end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
               state_d     = RESP;
               mem_read_d  = 1'b0;
               rsp_ready_d = NUM_REQ'(1) << grant_id_q;
               rsp_error_d = 1'b1;
               tmo_evt     = 1'b1;
            end else if (WDOG_EN) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         RESP: begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == LAST_ID) ? 2'd0 : grant_id_q + 2'd1;
         end
         default: begin
            state_d    = IDLE;
            mem_read_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 2'd0;
         grant_id_q  <= 2'd0;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         wdog_q      <= '0;
         rsp_ready_q <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         wdog_q      <= wdog_d;
         rsp_ready_q <= rsp_ready_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_ready = rsp_ready_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_error = rsp_error_q;
   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;

`ifdef PTW_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] stat_grants_q, stat_grants_d;
   logic [15:0]           stat_timeouts_q, stat_timeouts_d;

   always_comb begin
      stat_grants_d   = stat_grants_q;
      stat_timeouts_d = stat_timeouts_q;
      if (grant_evt && (stat_grants_q[int'(arb_id)*16 +: 16] != 16'hFFFF)) begin
         stat_grants_d[int'(arb_id)*16 +: 16] = stat_grants_q[int'(arb_id)*16 +: 16] + 16'd1;
      end
      if (tmo_evt && (stat_timeouts_q != 16'hFFFF)) begin
         stat_timeouts_d = stat_timeouts_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_grants_q   <= '0;
         stat_timeouts_q <= '0;
      end else begin
         stat_grants_q   <= stat_grants_d;
         stat_timeouts_q <= stat_timeouts_d;
      end
   end

   assign stat_grants   = stat_grants_q;
   assign stat_timeouts = stat_timeouts_q;
`else
   logic stats_unused;
   assign stats_unused  = grant_evt ^ tmo_evt;
   assign stat_grants   = '0;
   assign stat_timeouts = '0;
`endif

endmodule
